// File: rtl/s_axis_mm2s_pkg.sv
// Shared AXIS DMA definitions: FSM state encodings, default packet length and
// the clogb2 sizing helper. The MM2S receiver and the S2MM transmitter both use it.
package s_axis_mm2s_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    INIT_COUNTER = 2'b01,
    RECV_STREAM  = 2'b10
  } state_t;

  localparam int DEFAULT_PKT_WORDS = 1024;

  // Number of address bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    for (int i = 0; i < 32; i++) begin
      if (v > 32'sd0) begin
        r = r + 32'sd1;
        v = v >>> 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/s_axis_mm2s.sv
// AXI4-Stream slave receiving fixed-length DMA MM2S packets into a FIFO write port,
// with byte masking by TSTRB, packet counting and sticky framing-error flags.
module s_axis_mm2s
  import s_axis_mm2s_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_START_COUNT      = 32,
  parameter int C_PKT_WORDS          = DEFAULT_PKT_WORDS
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic                              ENABLE,
  input  logic                              FIFO_ALMOST_FULL,
  output logic                              FIFO_WR_EN,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   FIFO_DATA,
  input  logic                              ERR_CLR,
  output logic                              PKT_DONE,
  output logic [31:0]                       PKT_COUNT,
  output logic                              ERR_EARLY_LAST,
  output logic                              ERR_MISSING_LAST
);

  localparam int NB = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int CW = (clogb2(C_PKT_WORDS) < 1) ? 1 : clogb2(C_PKT_WORDS);
  localparam int WW = (clogb2(C_S_START_COUNT + 1) < 1) ? 1 : clogb2(C_S_START_COUNT + 1);
  localparam logic [CW-1:0] LAST_IDX   = CW'(C_PKT_WORDS - 1);
  localparam logic [WW-1:0] START_LAST = WW'(C_S_START_COUNT - 1);

  state_t                            state_r;
  state_t                            state_s;
  logic [WW-1:0]                     wait_cnt_r;
  logic [CW-1:0]                     word_cnt_r;
  logic                              accept_s;
  logic                              last_word_s;
  logic                              done_s;
  logic                              early_set_s;
  logic                              missing_set_s;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]   masked_s;

  assign S_AXIS_TREADY = (state_r == RECV_STREAM) && !FIFO_ALMOST_FULL;
  assign accept_s      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_word_s   = (word_cnt_r == LAST_IDX);
  assign done_s        = accept_s && S_AXIS_TLAST && last_word_s;
  assign early_set_s   = accept_s && S_AXIS_TLAST && !last_word_s;
  assign missing_set_s = accept_s && !S_AXIS_TLAST && last_word_s;

  // Zero every byte lane whose strobe is low.
  always_comb begin
    masked_s = {C_S_AXIS_TDATA_WIDTH{1'b0}};
    for (int b = 0; b < NB; b++) begin
      if (S_AXIS_TSTRB[b]) begin
        masked_s[8*b +: 8] = S_AXIS_TDATA[8*b +: 8];
      end else begin
        masked_s[8*b +: 8] = 8'h00;
      end
    end
  end

  // Next-state logic; leaving RECV_STREAM waits for a packet boundary with no beat in flight.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ENABLE) state_s = INIT_COUNTER;
        else        state_s = IDLE;
      end
      INIT_COUNTER: begin
        if (wait_cnt_r == START_LAST) state_s = RECV_STREAM;
        else                          state_s = INIT_COUNTER;
      end
      RECV_STREAM: begin
        if (!ENABLE && (word_cnt_r == {CW{1'b0}}) && !accept_s) state_s = IDLE;
        else                                                    state_s = RECV_STREAM;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and startup wait counter (held at zero outside INIT_COUNTER).
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == INIT_COUNTER) wait_cnt_r <= wait_cnt_r + WW'(1);
      else                         wait_cnt_r <= {WW{1'b0}};
    end
  end

  // FIFO write port, word index and packet completion.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      FIFO_WR_EN <= 1'b0;
      FIFO_DATA  <= {C_S_AXIS_TDATA_WIDTH{1'b0}};
      word_cnt_r <= {CW{1'b0}};
      PKT_DONE   <= 1'b0;
      PKT_COUNT  <= 32'd0;
    end else begin
      FIFO_WR_EN <= accept_s;
      PKT_DONE   <= done_s;
      if (accept_s) begin
        FIFO_DATA <= masked_s;
        if (S_AXIS_TLAST || last_word_s) word_cnt_r <= {CW{1'b0}};
        else                             word_cnt_r <= word_cnt_r + CW'(1);
      end else begin
        FIFO_DATA  <= FIFO_DATA;
        word_cnt_r <= word_cnt_r;
      end
      if (done_s) PKT_COUNT <= PKT_COUNT + 32'd1;
      else        PKT_COUNT <= PKT_COUNT;
    end
  end

  // Sticky framing errors; a new error wins over a simultaneous clear.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      ERR_EARLY_LAST   <= 1'b0;
      ERR_MISSING_LAST <= 1'b0;
    end else begin
      if (early_set_s)  ERR_EARLY_LAST <= 1'b1;
      else if (ERR_CLR) ERR_EARLY_LAST <= 1'b0;
      else              ERR_EARLY_LAST <= ERR_EARLY_LAST;
      if (missing_set_s) ERR_MISSING_LAST <= 1'b1;
      else if (ERR_CLR)  ERR_MISSING_LAST <= 1'b0;
      else               ERR_MISSING_LAST <= ERR_MISSING_LAST;
    end
  end

endmodule

// File: tb/tb_s_axis_mm2s.sv
// Scoreboard bench for s_axis_mm2s: the driver queues the expected FIFO word and
// write edge for every accepted beat; a negedge monitor pops and compares writes.
`timescale 1ns/1ps
module tb_s_axis_mm2s;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic [3:0]  tstrb = 4'h0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        enable = 1'b0;
  logic        almost_full = 1'b0;
  logic        wr_en;
  logic [31:0] fifo_data;
  logic        err_clr = 1'b0;
  logic        pkt_done;
  logic [31:0] pkt_count;
  logic        err_early;
  logic        err_missing;

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  s_axis_mm2s dut (
    .S_AXIS_ACLK      (clk),
    .S_AXIS_ARESET    (rst),
    .S_AXIS_TVALID    (tvalid),
    .S_AXIS_TDATA     (tdata),
    .S_AXIS_TSTRB     (tstrb),
    .S_AXIS_TLAST     (tlast),
    .S_AXIS_TREADY    (tready),
    .ENABLE           (enable),
    .FIFO_ALMOST_FULL (almost_full),
    .FIFO_WR_EN       (wr_en),
    .FIFO_DATA        (fifo_data),
    .ERR_CLR          (err_clr),
    .PKT_DONE         (pkt_done),
    .PKT_COUNT        (pkt_count),
    .ERR_EARLY_LAST   (err_early),
    .ERR_MISSING_LAST (err_missing)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest queued beat and land on its accept edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wr_en) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {31'd0, wr_en}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("fifo_data", fifo_data, e.data);
          chk("write_latency", cyc, e.edge_no);
        end
      end
      if (pkt_done) done_cnt++;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic last,
                           input logic [31:0] exp);
    bit got;
    tvalid = 1'b1;
    tdata  = d;
    tstrb  = s;
    tlast  = last;
    got    = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (tready) begin
        q.push_back('{data: exp, edge_no: cyc + 1});
        got = 1'b1;
      end
    end
    if (!got) chk("tready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // Words carry their index; optional stall, ENABLE drop, ERR_CLR and strobe patterns.
  task automatic send_pkt(input int n, input int last_idx, input int stall_at,
                          input int dis_at, input int clr_at, input bit strb_vec);
    logic [31:0] d;
    logic [31:0] e;
    logic [3:0]  s;
    for (int i = 0; i < n; i++) begin
      d = i;
      e = i;
      s = 4'hF;
      if (strb_vec && i == 5) begin d = 32'hAABBCCDD; s = 4'b0101; e = 32'h00BB00DD; end
      if (strb_vec && i == 6) begin d = 32'h11223344; s = 4'b1010; e = 32'h11003300; end
      if (strb_vec && i == 7) begin d = 32'hFFFFFFFF; s = 4'b0000; e = 32'h00000000; end
      if (i == dis_at) enable = 1'b0;
      err_clr = (i == clr_at);
      if (i == stall_at) begin
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        almost_full = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("tready_during_stall", {31'd0, tready}, 32'd0);
        end
        @(posedge clk);
        #1;
        almost_full = 1'b0;
      end
      send_word(d, s, (i == last_idx), e);
      err_clr = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
  endtask

  task automatic check_zero_outputs();
    chk("rst_tready", {31'd0, tready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_fifo_data", fifo_data, 32'd0);
    chk("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_pkt_count", pkt_count, 32'd0);
    chk("rst_err_early", {31'd0, err_early}, 32'd0);
    chk("rst_err_missing", {31'd0, err_missing}, 32'd0);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    almost_full = 1'b0;
    err_clr = 1'b0;
    rst = 1'b1;
    q.delete();
    #1;
    check_zero_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start();
    int e0;
    bit seen;
    enable = 1'b1;
    e0 = cyc;
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (tready) seen = 1'b1;
    end
    chk("tready_latency", seen ? (cyc - e0) : 32'hFFFF_FFFF, 32'd33);
    @(posedge clk);
    #1;
  endtask

  int d0;

  initial begin
    // Nominal packet; ENABLE dropped mid-packet must not cut it short.
    do_reset();
    start();
    d0 = done_cnt;
    send_pkt(1024, 1023, -1, 10, -1, 1'b0);
    settle();
    chk("p1_pkt_count", pkt_count, 32'd1);
    chk("p1_done_pulses", done_cnt - d0, 32'd1);
    chk("p1_err_early", {31'd0, err_early}, 32'd0);
    chk("p1_err_missing", {31'd0, err_missing}, 32'd0);
    chk("p1_tready_after_disable", {31'd0, tready}, 32'd0);

    // Early TLAST on word 99 with ERR_CLR in the same cycle, strobe patterns, then recovery.
    do_reset();
    start();
    d0 = done_cnt;
    send_pkt(100, 99, -1, -1, 99, 1'b1);
    settle();
    chk("early_flag", {31'd0, err_early}, 32'd1);
    chk("early_missing_flag", {31'd0, err_missing}, 32'd0);
    chk("early_pkt_count", pkt_count, 32'd0);
    chk("early_done_pulses", done_cnt - d0, 32'd0);
    send_pkt(1024, 1023, -1, -1, -1, 1'b0);
    settle();
    chk("early_next_pkt_count", pkt_count, 32'd1);
    chk("early_flag_sticky", {31'd0, err_early}, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("early_flag_cleared", {31'd0, err_early}, 32'd0);

    // Missing TLAST on word 1023; next word starts a fresh packet.
    do_reset();
    start();
    d0 = done_cnt;
    send_pkt(1024, -1, -1, -1, -1, 1'b0);
    settle();
    chk("missing_flag", {31'd0, err_missing}, 32'd1);
    chk("missing_early_flag", {31'd0, err_early}, 32'd0);
    chk("missing_pkt_count", pkt_count, 32'd0);
    send_pkt(1024, 1023, -1, -1, -1, 1'b0);
    settle();
    chk("realigned_pkt_count", pkt_count, 32'd1);
    chk("realigned_done_pulses", done_cnt - d0, 32'd1);

    // Reset asserted right after word 299 is accepted, then a stalled full packet.
    send_pkt(300, -1, -1, -1, -1, 1'b0);
    rst = 1'b1;
    q.delete();
    #1;
    check_zero_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start();
    d0 = done_cnt;
    send_pkt(1024, 1023, 500, -1, -1, 1'b0);
    settle();
    chk("post_rst_pkt_count", pkt_count, 32'd1);
    chk("post_rst_done_pulses", done_cnt - d0, 32'd1);
    chk("post_rst_err_early", {31'd0, err_early}, 32'd0);
    chk("post_rst_err_missing", {31'd0, err_missing}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
